// File: rtl/axis_adc_capture.sv
// ---------------------------------------------------------------------------
// axis_adc_capture
//
// Captures 1..4 ADC channels and runs each sample through these stages:
//   - a two-stage synchroniser
//   - optional offset-binary to two's-complement conversion
//   - power-of-two boxcar decimation
//   - packing into AXI-Stream words
//   - a show-ahead FIFO
// The stream is emitted in frames of programmable length, and m_axis_last
// marks the final word of each frame.
//
// Ports
//   in_adc_clk      ADC sample clock; every register uses its rising edge
//   in_rst          asynchronous active-high reset
//   in_adc_data     packed samples; channel c sits at [c*W +: W]
//   in_start        begin a capture (honoured only in IDLE)
//   in_stop         abort a capture (honoured only in CAPTURE)
//   in_frame_len    words per frame, latched at start; 0 = continuous
//   m_axis_ready    downstream ready
//   m_axis_valid    FIFO head valid
//   m_axis_data     packed averaged samples, channel c at [c*LANE +: LANE]
//   m_axis_last     head word closes a frame
//   out_busy        FSM is not IDLE
//   out_overflow    sticky, set when a word is dropped on a full FIFO
//   out_drop_count  dropped words, saturating at 0xFFFF
//   out_adc_data    synchronised and converted samples for monitoring
// ---------------------------------------------------------------------------
module axis_adc_capture #(
  parameter int   INT_ADC_CHANNELS    = 2,
  parameter int   INT_ADC_DATA_WIDTH  = 14,
  parameter int   INT_AXIS_DATA_WIDTH = 32,
  parameter int   INT_DECIM_LOG2      = 2,
  parameter int   INT_FIFO_DEPTH      = 16,
  parameter int   INT_FRAME_LEN_WIDTH = 16,
  parameter logic BIT_OFFSET_BINARY   = 1'b0
) (
  input  logic                                           in_adc_clk,
  input  logic                                           in_rst,
  input  logic [INT_ADC_CHANNELS*INT_ADC_DATA_WIDTH-1:0] in_adc_data,
  input  logic                                           in_start,
  input  logic                                           in_stop,
  input  logic [INT_FRAME_LEN_WIDTH-1:0]                 in_frame_len,
  input  logic                                           m_axis_ready,
  output logic                                           m_axis_valid,
  output logic [INT_AXIS_DATA_WIDTH-1:0]                 m_axis_data,
  output logic                                           m_axis_last,
  output logic                                           out_busy,
  output logic                                           out_overflow,
  output logic [15:0]                                    out_drop_count,
  output logic [INT_ADC_CHANNELS*INT_ADC_DATA_WIDTH-1:0] out_adc_data
);

  localparam int CH    = INT_ADC_CHANNELS;
  localparam int W     = INT_ADC_DATA_WIDTH;
  localparam int AXW   = INT_AXIS_DATA_WIDTH;
  localparam int K     = INT_DECIM_LOG2;
  localparam int DEPTH = INT_FIFO_DEPTH;
  localparam int FLW   = INT_FRAME_LEN_WIDTH;
  localparam int LANE  = AXW / ((CH > 0) ? CH : 1);
  localparam int ACCW  = W + K;
  localparam int PHW   = (K > 0) ? K : 1;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [PHW-1:0] PH_MAX  = PHW'((1 << K) - 1);
  localparam logic [PHW-1:0] PH_ONE  = PHW'(1);
  localparam logic [FLW-1:0] LEN_ONE = FLW'(1);
  localparam logic [AW:0]    PTR_ONE = (AW + 1)'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  generate
    if (CH < 1 || CH > 4) begin : g_bad_channels
      $error("axis_adc_capture: INT_ADC_CHANNELS must be 1..4");
    end
    if (LANE < W) begin : g_bad_lane
      $error("axis_adc_capture: lane width smaller than INT_ADC_DATA_WIDTH");
    end
    if (K < 0 || K > 8) begin : g_bad_decim
      $error("axis_adc_capture: INT_DECIM_LOG2 must be 0..8");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_adc_capture: INT_FIFO_DEPTH must be a power of two >= 4");
    end
  endgenerate

  logic [CH*W-1:0]           r_sync1;
  logic [CH*W-1:0]           r_sync2;
  logic [CH*W-1:0]           w_conv;
  logic [CH-1:0][ACCW-1:0]   r_acc;
  logic [CH-1:0][ACCW-1:0]   w_sum;
  logic [CH-1:0][ACCW-1:0]   w_shift;
  logic [AXW-1:0]            w_word;
  logic [AXW-1:0]            r_word;
  logic [PHW-1:0]            r_phase;
  logic                      r_push_req;
  logic [1:0]                r_state;
  logic [FLW-1:0]            r_len;
  logic [FLW-1:0]            r_frame_cnt;
  logic                      r_overflow;
  logic [15:0]               r_drop_cnt;
  logic [AXW:0]              r_mem [DEPTH];
  logic [AW:0]               r_wr_ptr;
  logic [AW:0]               r_rd_ptr;
  logic [AXW:0]              w_head;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push_try;
  logic                      w_push;
  logic                      w_drop;
  logic                      w_frame_last;

  // The MSB flip is folded into the second stage, so that stage already
  // holds two's-complement samples and its reset value reads as zero.
  always_comb begin
    w_conv = r_sync1;
    if (BIT_OFFSET_BINARY) begin
      for (int c = 0; c < CH; c++) begin
        w_conv[c*W + W - 1] = ~r_sync1[c*W + W - 1];
      end
    end
  end

  // The synchroniser runs in every FSM state so that the monitor output
  // always tracks the pins.
  always_ff @(posedge in_adc_clk or posedge in_rst) begin
    if (in_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_adc_data;
      r_sync2 <= w_conv;
    end
  end

  // Running sum including the current sample. The arithmetic shift floors
  // the average, and the result is then sign-extended into its lane.
  // Lane bits above CH*LANE stay zero.
  always_comb begin
    w_sum   = '0;
    w_shift = '0;
    w_word  = '0;
    for (int c = 0; c < CH; c++) begin
      w_sum[c]   = r_acc[c] + ACCW'($signed(r_sync2[c*W +: W]));
      w_shift[c] = ACCW'($signed(w_sum[c]) >>> K);
      w_word[c*LANE +: LANE] = LANE'($signed(w_shift[c][W-1:0]));
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_axis_ready;

  // A pending result is pushed only while capturing. A stop in the same
  // cycle kills it, and on a full FIFO a simultaneous pop makes room.
  assign w_push_try   = r_push_req && (r_state == ST_CAPTURE) && !in_stop;
  assign w_push       = w_push_try && (!w_full || w_pop);
  assign w_drop       = w_push_try && w_full && !w_pop;
  assign w_frame_last = (r_len != '0) && (r_frame_cnt == r_len - LEN_ONE);

  // FIFO storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge in_adc_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_frame_last, r_word};
    end
  end

  always_ff @(posedge in_adc_clk or posedge in_rst) begin
    if (in_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Capture FSM with decimation and frame accounting. Dropped words do not
  // advance the frame counter, so every completed frame is full length.
  always_ff @(posedge in_adc_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_acc       <= '0;
      r_phase     <= '0;
      r_push_req  <= 1'b0;
      r_word      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_push_req <= 1'b0;
          if (in_start) begin
            r_state     <= ST_CAPTURE;
            r_len       <= in_frame_len;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_acc       <= '0;
            r_phase     <= '0;
          end
        end
        ST_CAPTURE: begin
          if (in_stop) begin
            r_state    <= ST_DRAIN;
            r_acc      <= '0;
            r_phase    <= '0;
            r_push_req <= 1'b0;
          end else begin
            if (r_phase == PH_MAX) begin
              r_word     <= w_word;
              r_push_req <= 1'b1;
              r_acc      <= '0;
              r_phase    <= '0;
            end else begin
              r_acc      <= w_sum;
              r_push_req <= 1'b0;
              r_phase    <= r_phase + PH_ONE;
            end
            if (w_push) begin
              if (w_frame_last) begin
                r_state     <= ST_DRAIN;
                r_frame_cnt <= '0;
              end else begin
                r_frame_cnt <= r_frame_cnt + LEN_ONE;
              end
            end
            if (w_drop) begin
              r_overflow <= 1'b1;
              if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
              end
            end
          end
        end
        ST_DRAIN: begin
          r_push_req <= 1'b0;
          if (w_empty) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_push_req <= 1'b0;
        end
      endcase
    end
  end

  // Data and last are gated with valid so that every output reads zero
  // while the FIFO is empty, including straight after reset.
  assign w_head         = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis_valid   = !w_empty;
  assign m_axis_data    = w_empty ? '0 : w_head[AXW-1:0];
  assign m_axis_last    = !w_empty && w_head[AXW];
  assign out_busy       = (r_state != ST_IDLE);
  assign out_overflow   = r_overflow;
  assign out_drop_count = r_drop_cnt;
  assign out_adc_data   = r_sync2;

endmodule
